piso: RTL

- Parallel-in/serial-out unloader; the transmit-side counterpart of the SIPO register bank.
- Accepts one REG_NUM-word parallel vector and emits it one complex word (2*DATA_WIDTH bits) per beat.
- Slice 0 is emitted first and slice REG_NUM-1 last, so s_out/s_valid can drive a SIPO's s_in/load directly (s_ready tied 1) and reproduce the vector.
- Sits at the PE-array result path, draining parallel register contents onto the serial bus.

---
 rtl/piso.sv | 132 +++++++++++++
 1 files changed

// File: rtl/piso.sv
// piso: parallel-in / serial-out unloader.
// Captures one REG_NUM-word parallel vector and emits it one complex word
// (2*DATA_WIDTH bits) per serial transfer, word 0 first. A new vector may be
// accepted on the last-beat cycle, so back-to-back vectors stream with no gap.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   p_in     parallel vector, word k = p_in[(k+1)*2*DATA_WIDTH-1 : k*2*DATA_WIDTH]
//   p_valid  p_in valid
//   p_ready  block can accept p_in this cycle (combinational)
//   s_out    current serial word (registered)
//   s_valid  s_out valid (registered)
//   s_ready  downstream accepts s_out this cycle
//   s_idx    index of the word currently on s_out (registered)
//   done     one-cycle pulse in the cycle after the last word transfers
module piso #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned REG_NUM    = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [REG_NUM*DATA_WIDTH*2-1:0]   p_in,
    input  logic                              p_valid,
    output logic                              p_ready,
    output logic [DATA_WIDTH*2-1:0]           s_out,
    output logic                              s_valid,
    input  logic                              s_ready,
    output logic [$clog2(REG_NUM)-1:0]        s_idx,
    output logic                              done
);

    localparam int unsigned WW       = 2 * DATA_WIDTH;
    localparam int unsigned VW       = REG_NUM * WW;
    localparam int unsigned IDX_W    = $clog2(REG_NUM);
    localparam int unsigned LAST_IDX = REG_NUM - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [VW-1:0]      shadow_q, shadow_d;
    logic [WW-1:0]      s_out_q, s_out_d;
    logic               s_valid_q, s_valid_d;
    logic [IDX_W-1:0]   s_idx_q, s_idx_d;
    logic               done_q, done_d;

    logic               last_c;
    logic               xfer_c;
    logic               accept_c;

    // Handshake decode; the last-beat window is what allows gapless streaming.
    always_comb begin
        last_c   = (s_idx_q == IDX_W'(LAST_IDX));
        xfer_c   = s_valid_q & s_ready;
        p_ready  = (state_q == IDLE) | ((state_q == SHIFT) & last_c & s_ready);
        accept_c = p_valid & p_ready;
    end

    // Next-state and datapath. The shadow holds the words not yet presented,
    // lowest word next, so each transfer is a plain one-word right shift.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        s_out_d   = s_out_q;
        s_valid_d = s_valid_q;
        s_idx_d   = s_idx_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    shadow_d  = VW'(p_in >> WW);
                    s_out_d   = p_in[WW-1:0];
                    s_idx_d   = '0;
                    s_valid_d = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer_c) begin
                    if (!last_c) begin
                        s_out_d  = shadow_q[WW-1:0];
                        shadow_d = VW'(shadow_q >> WW);
                        s_idx_d  = s_idx_q + IDX_W'(1);
                    end else begin
                        done_d = 1'b1;
                        if (accept_c) begin
                            shadow_d  = VW'(p_in >> WW);
                            s_out_d   = p_in[WW-1:0];
                            s_idx_d   = '0;
                            s_valid_d = 1'b1;
                        end else begin
                            s_out_d   = '0;
                            s_idx_d   = '0;
                            s_valid_d = 1'b0;
                            state_d   = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            s_out_q   <= '0;
            s_valid_q <= 1'b0;
            s_idx_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            s_out_q   <= s_out_d;
            s_valid_q <= s_valid_d;
            s_idx_q   <= s_idx_d;
            done_q    <= done_d;
        end
    end

    assign s_out   = s_out_q;
    assign s_valid = s_valid_q;
    assign s_idx   = s_idx_q;
    assign done    = done_q;

endmodule
